exec_trace_buffer: RTL and testbench
====================================

// Module: exec_trace_buffer
// PURPOSE
//  Synthesizable instruction-trace capture unit for the single-cycle datapath core.
//  - Samples retired {pc, opcode, result} into a parametrised FIFO and keeps per-class instruction counters.
//  - Supports an opcode filter, overflow policy and optional trigger, replacing $monitor-style printing.
//  - Sits beside the datapath top. Drained by a bench or debug port over a valid/ready handshake.
// PARAMETERS
//  DATA_W    32  width of the captured result
//  PC_W      8   width of the captured pc
//  DEPTH     16  trace entries; power of two, >=2
//  CNT_W     16  width of the class counters and the drop counter (all saturating)
//  OVERWRITE 0   full policy: 0 = drop the new entry, 1 = discard the oldest entry (ring buffer)
//  POST_TRIG 8   captures taken after the trigger before freezing; used only with TRACE_TRIG_EN
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          asynchronous, active-high reset
//  clr_i        in   1          synchronous clear of FIFO, counters, flags and FSM (to IDLE)
//  en_i         in   1          capture enable
//  valid_i      in   1          pc_i/opcode_i/result_i describe one retired instruction this cycle
//  pc_i         in   PC_W       instruction pc
//  opcode_i     in   6          instruction opcode
//  result_i     in   DATA_W     datapath result
//  filt_mask_i  in   6          opcode filter mask
//  filt_val_i   in   6          opcode filter value
//  trig_op_i    in   6          trigger opcode; ignored without TRACE_TRIG_EN
//  rd_valid_o   out  1          FIFO not empty
//  rd_ready_i   in   1          consumer pops when rd_valid_o && rd_ready_i
//  rd_pc_o      out  PC_W       head entry pc (fall-through)
//  rd_opcode_o  out  6          head entry opcode
//  rd_result_o  out  DATA_W     head entry result
//  level_o      out  $clog2(DEPTH)+1  entries held
//  overflow_o   out  1          sticky: at least one entry was lost
//  drop_cnt_o   out  CNT_W      number of lost entries
//  cnt_r_o      out  CNT_W      count of R-class instructions
//  cnt_i_o      out  CNT_W      count of I-class instructions
//  cnt_j_o      out  CNT_W      count of J-class instructions
//  frozen_o     out  1          FSM is in FROZEN
// BEHAVIOUR
//  - Reset (rst) and clr_i: all outputs 0, pointers 0, FSM in IDLE. rd_* outputs are 0 while the FIFO is empty.
//  - FSM states: IDLE -> RUN when en_i=1. RUN -> IDLE when en_i=0; FIFO contents are kept.
//  - Sample (hit): valid_i && state==RUN && ((opcode_i & filt_mask_i) == (filt_val_i & filt_mask_i)).
//  - Counters: every valid_i in RUN increments exactly one class counter; the filter does not apply.
//    - Classes: R = {0-5, 15, 24}; I = {6-14, 16-21}; J = {22, 23}; other opcodes are counted nowhere.
//    - All counters saturate at 2^CNT_W-1.
//  - Latency: an entry accepted at edge N shows rd_valid_o=1 and its data after edge N.
//    Pop is combinational on the head entry; the pointer advances at the edge.
//  - Full and hit with a pop in the same cycle: both the push and the pop happen; level_o is unchanged.
//  - Full and hit without a pop:
//    - OVERWRITE=0: the new entry is dropped; overflow_o=1 and drop_cnt_o+1.
//    - OVERWRITE=1: the oldest entry is discarded (rd pointer +1) and the new entry is written;
//      overflow_o=1 and drop_cnt_o+1; level_o stays at DEPTH.
//  - Empty: a pop is ignored. level_o never underflows.
//  - Pointers wrap modulo DEPTH. level_o = DEPTH when full.
//  - rst asserted mid-operation aborts immediately; no partial entry survives.
// CONFIGURATION
//  - TRACE_TRIG_EN defined: added FSM states ARMED and FROZEN. IDLE -en_i-> ARMED.
//    - In ARMED, counters run and there is no capture.
//    - valid_i && opcode_i==trig_op_i in ARMED: move to RUN and capture that instruction (subject to the filter) as the first entry.
//    - After POST_TRIG accepted pushes (the trigger included): FROZEN. Counters and capture stop and frozen_o=1.
//    - Draining is still allowed in FROZEN. Only clr_i or rst leaves FROZEN.
//  - TRACE_TRIG_EN undefined: there is no ARMED or FROZEN state, frozen_o is tied to 0 and trig_op_i is unused.
// STRUCTURE
//  - Package trace_pkg:
//    - opcode localparams OP_ADD..OP_JR, values 0..24;
//    - opcode class enum {CLS_R, CLS_I, CLS_J, CLS_NONE} and function op_class(opcode);
//    - FSM state encoding.
//  - Sub-module trace_fifo: a parametrised DATA/DEPTH FIFO with an OVERWRITE policy, level and a push-drop strobe.
//    The top module holds the FSM, filter and counters.
// TESTING
//  - Reset, then 3 pushes (pc 0,4,8; opcode 0,6,22) -> level_o=3; pops return the same order; cnt_r/i/j=1/1/1.
//  - OVERWRITE=0, DEPTH=4, 6 pushes with no pop -> level_o=4; head pc=0; drop_cnt_o=2; overflow_o=1.
//  - OVERWRITE=1, same stimulus -> head pc is the 3rd entry; level_o=4; drop_cnt_o=2.
//  - Full FIFO, push and pop in the same cycle -> level_o stays 4; the popped entry is the oldest; drop_cnt_o unchanged.
//  - filt_mask_i=6'h3F, filt_val_i=OP_LW, mixed stream -> only LW entries are captured; class counters count every instruction.
//  - TRACE_TRIG_EN, POST_TRIG=2, trig_op_i=OP_BEQ -> ADD, SUB not captured; BEQ and the next instruction are captured;
//    frozen_o=1; later instructions are ignored; clr_i -> IDLE.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the execution trace buffer: opcode numbering,
// opcode class decode and the capture FSM state encoding.
// Build option: TRACE_TRIG_EN adds the ARMED and FROZEN trigger states.
package trace_pkg;

    // Opcode numbering of the single-cycle datapath core
    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;
    localparam logic [5:0] OP_SLT  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd6;
    localparam logic [5:0] OP_ANDI = 6'd7;
    localparam logic [5:0] OP_ORI  = 6'd8;
    localparam logic [5:0] OP_XORI = 6'd9;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_LUI  = 6'd11;
    localparam logic [5:0] OP_LW   = 6'd12;
    localparam logic [5:0] OP_SW   = 6'd13;
    localparam logic [5:0] OP_BEQ  = 6'd14;
    localparam logic [5:0] OP_SLL  = 6'd15;
    localparam logic [5:0] OP_BNE  = 6'd16;
    localparam logic [5:0] OP_BLT  = 6'd17;
    localparam logic [5:0] OP_BGE  = 6'd18;
    localparam logic [5:0] OP_LB   = 6'd19;
    localparam logic [5:0] OP_SB   = 6'd20;
    localparam logic [5:0] OP_SLLI = 6'd21;
    localparam logic [5:0] OP_J    = 6'd22;
    localparam logic [5:0] OP_JAL  = 6'd23;
    localparam logic [5:0] OP_JR   = 6'd24;

    typedef enum logic [1:0] {
        CLS_R    = 2'd0,
        CLS_I    = 2'd1,
        CLS_J    = 2'd2,
        CLS_NONE = 2'd3
    } op_class_e;

    // R = {0-5, SLL, JR}; I = {6-14, 16-21}; J = {J, JAL}; anything else is unclassified
    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e cls;
        cls = CLS_NONE;
        if (op <= OP_SLT || op == OP_SLL || op == OP_JR) begin
            cls = CLS_R;
        end else if ((op >= OP_ADDI && op <= OP_BEQ) || (op >= OP_BNE && op <= OP_SLLI)) begin
            cls = CLS_I;
        end else if (op == OP_J || op == OP_JAL) begin
            cls = CLS_J;
        end
        return cls;
    endfunction

`ifdef TRACE_TRIG_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_ARMED  = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_e;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } trace_state_e;
`endif

endpackage

// File: rtl/trace_fifo.sv
// Parametrised trace FIFO with a selectable full policy.
// OVERWRITE=0 drops a push into a full FIFO; OVERWRITE=1 discards the oldest
// entry instead. push_ok marks a push that was written, drop marks a lost entry.
// Read data falls through from the head entry and is forced to 0 when empty.
module trace_fifo #(
    parameter int W         = 46,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     push_ok,
    output logic                     drop
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             wr_en;
    logic             rd_adv;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LVL_W'(DEPTH));
    assign do_pop = pop && !empty;

    // Decide write, read-advance and drop for this cycle; a clear suppresses all of them
    always_comb begin
        wr_en  = 1'b0;
        rd_adv = do_pop;
        drop   = 1'b0;
        if (push) begin
            if (!full || do_pop) begin
                wr_en = 1'b1;
            end else if (OVERWRITE) begin
                wr_en  = 1'b1;
                rd_adv = 1'b1;
                drop   = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        if (clr) begin
            wr_en  = 1'b0;
            rd_adv = 1'b0;
            drop   = 1'b0;
        end
    end

    // Storage array; not reset because pointers and level gate every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks pushes minus pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_en && !rd_adv) begin
                level_q <= level_q + LVL_W'(1);
            end else if (!wr_en && rd_adv) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    assign rdata   = empty ? '0 : mem[rd_ptr_q];
    assign valid   = !empty;
    assign level   = level_q;
    assign push_ok = wr_en;

endmodule

// File: rtl/exec_trace_buffer.sv
// Instruction-trace capture unit beside the datapath top.
// Holds the capture FSM, the opcode filter, per-class counters and the
// drop/overflow bookkeeping; entries live in trace_fifo.
// Build option: TRACE_TRIG_EN enables trigger-based capture (ARMED/FROZEN).
// Drain handshake: rd_valid_o means the head entry is on rd_*; the entry is
// consumed at the rising edge where rd_valid_o && rd_ready_i; rd_ready_i may
// be held high while empty and has no effect then.
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 16,
    parameter bit OVERWRITE = 1'b0,
    parameter int POST_TRIG = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic                   valid_i,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [5:0]             opcode_i,
    input  logic [DATA_W-1:0]      result_i,
    input  logic [5:0]             filt_mask_i,
    input  logic [5:0]             filt_val_i,
    input  logic [5:0]             trig_op_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [PC_W-1:0]        rd_pc_o,
    output logic [5:0]             rd_opcode_o,
    output logic [DATA_W-1:0]      rd_result_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    output logic [CNT_W-1:0]       drop_cnt_o,
    output logic [CNT_W-1:0]       cnt_r_o,
    output logic [CNT_W-1:0]       cnt_i_o,
    output logic [CNT_W-1:0]       cnt_j_o,
    output logic                   frozen_o
);

    localparam int ENT_W = PC_W + 6 + DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    trace_state_e     state_q;
    trace_state_e     state_d;
    logic             filt_match;
    logic             count_en;
    logic             hit;
    logic             push_ok;
    logic             drop;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;
    op_class_e        cls;
    logic [CNT_W-1:0] cnt_r_q;
    logic [CNT_W-1:0] cnt_i_q;
    logic [CNT_W-1:0] cnt_j_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic             overflow_q;

    assign filt_match = ((opcode_i & filt_mask_i) == (filt_val_i & filt_mask_i));
    assign cls        = op_class(opcode_i);
    assign wr_entry   = {pc_i, opcode_i, result_i};

`ifdef TRACE_TRIG_EN
    logic        trig_fire;
    logic [15:0] post_cnt_q;
    logic        post_done;

    assign trig_fire = valid_i && (state_q == ST_ARMED) && (opcode_i == trig_op_i);
    assign count_en  = valid_i && ((state_q == ST_RUN) || (state_q == ST_ARMED));
    assign hit       = filt_match && ((valid_i && (state_q == ST_RUN)) || trig_fire);
    // True when the push accepted this cycle is the last one before freezing
    assign post_done = push_ok && ((32'(post_cnt_q) + 32'd1) >= 32'(POST_TRIG));

    // Next state: the trigger takes priority over en_i dropping in ARMED
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (trig_fire) begin
                    state_d = (push_ok && (POST_TRIG <= 1)) ? ST_FROZEN : ST_RUN;
                end else if (!en_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (post_done) state_d = ST_FROZEN;
                else if (!en_i) state_d = ST_IDLE;
            end
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Count accepted pushes since the trigger, trigger capture included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_cnt_q <= '0;
        end else if (clr_i) begin
            post_cnt_q <= '0;
        end else if (trig_fire) begin
            post_cnt_q <= push_ok ? 16'd1 : 16'd0;
        end else if ((state_q == ST_RUN) && push_ok && (post_cnt_q != 16'hFFFF)) begin
            post_cnt_q <= post_cnt_q + 16'd1;
        end
    end

    assign frozen_o = (state_q == ST_FROZEN);
`else
    logic unused_trig;

    assign count_en = valid_i && (state_q == ST_RUN);
    assign hit      = count_en && filt_match;

    // Next state: plain enable-driven capture
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en_i)  state_d = ST_RUN;
            ST_RUN:  if (!en_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign unused_trig = ^{trig_op_i, push_ok, 16'(POST_TRIG)};
    assign frozen_o    = 1'b0;
`endif

    // FSM state register; clear returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (clr_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-class retired-instruction counters, saturating; the filter does not apply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r_q <= '0;
            cnt_i_q <= '0;
            cnt_j_q <= '0;
        end else if (clr_i) begin
            cnt_r_q <= '0;
            cnt_i_q <= '0;
            cnt_j_q <= '0;
        end else if (count_en) begin
            case (cls)
                CLS_R: if (cnt_r_q != CNT_MAX) cnt_r_q <= cnt_r_q + CNT_W'(1);
                CLS_I: if (cnt_i_q != CNT_MAX) cnt_i_q <= cnt_i_q + CNT_W'(1);
                CLS_J: if (cnt_j_q != CNT_MAX) cnt_j_q <= cnt_j_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Lost-entry bookkeeping: sticky overflow flag and saturating drop count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clr_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != CNT_MAX) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    trace_fifo #(
        .W         (ENT_W),
        .DEPTH     (DEPTH),
        .OVERWRITE (OVERWRITE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_i),
        .push    (hit),
        .wdata   (wr_entry),
        .pop     (rd_ready_i),
        .rdata   (rd_entry),
        .valid   (rd_valid_o),
        .level   (level_o),
        .push_ok (push_ok),
        .drop    (drop)
    );

    assign rd_pc_o     = rd_entry[ENT_W-1 -: PC_W];
    assign rd_opcode_o = rd_entry[DATA_W +: 6];
    assign rd_result_o = rd_entry[DATA_W-1:0];
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign cnt_r_o     = cnt_r_q;
    assign cnt_i_o     = cnt_i_q;
    assign cnt_j_o     = cnt_j_q;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed scoreboard bench for exec_trace_buffer: two DEPTH=4 instances,
// one per full policy, share one stimulus stream.
module tb_exec_trace_buffer;
  import trace_pkg::*;

  logic clk, rst, clr_i, en_i, valid_i, rd_ready;
  logic [7:0] pc_i;
  logic [5:0] opcode_i, filt_mask_i, filt_val_i, trig_op_i;
  logic [31:0] result_i;

  logic a_valid, a_ovf, a_frz, b_valid, b_ovf, b_frz;
  logic [7:0] a_pc, b_pc;
  logic [5:0] a_op, b_op;
  logic [31:0] a_res, b_res;
  logic [2:0] a_level, b_level;
  logic [15:0] a_drop, a_r, a_i, a_j, b_drop, b_r, b_i, b_j;

  logic [45:0] exp_a[$];
  logic [45:0] exp_b[$];
  logic [45:0] ea, eb;
  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  exec_trace_buffer #(.DATA_W(32), .PC_W(8), .DEPTH(4), .CNT_W(16), .OVERWRITE(1'b0), .POST_TRIG(2)) dut_a (
    .clk(clk), .rst(rst), .clr_i(clr_i), .en_i(en_i), .valid_i(valid_i), .pc_i(pc_i),
    .opcode_i(opcode_i), .result_i(result_i), .filt_mask_i(filt_mask_i), .filt_val_i(filt_val_i),
    .trig_op_i(trig_op_i), .rd_valid_o(a_valid), .rd_ready_i(rd_ready), .rd_pc_o(a_pc),
    .rd_opcode_o(a_op), .rd_result_o(a_res), .level_o(a_level), .overflow_o(a_ovf),
    .drop_cnt_o(a_drop), .cnt_r_o(a_r), .cnt_i_o(a_i), .cnt_j_o(a_j), .frozen_o(a_frz));

  exec_trace_buffer #(.DATA_W(32), .PC_W(8), .DEPTH(4), .CNT_W(16), .OVERWRITE(1'b1), .POST_TRIG(2)) dut_b (
    .clk(clk), .rst(rst), .clr_i(clr_i), .en_i(en_i), .valid_i(valid_i), .pc_i(pc_i),
    .opcode_i(opcode_i), .result_i(result_i), .filt_mask_i(filt_mask_i), .filt_val_i(filt_val_i),
    .trig_op_i(trig_op_i), .rd_valid_o(b_valid), .rd_ready_i(rd_ready), .rd_pc_o(b_pc),
    .rd_opcode_o(b_op), .rd_result_o(b_res), .level_o(b_level), .overflow_o(b_ovf),
    .drop_cnt_o(b_drop), .cnt_r_o(b_r), .cnt_i_o(b_i), .cnt_j_o(b_j), .frozen_o(b_frz));

  function automatic logic [31:0] res_of(input logic [7:0] pc);
    return 32'hA500_0000 | {24'd0, pc};
  endfunction

  function automatic logic [45:0] ent(input logic [7:0] pc, input logic [5:0] op);
    return {pc, op, res_of(pc)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: compare every handshake against the expected queue
  always @(negedge clk) begin
    if (!rst && rd_ready) begin
      if (a_valid) begin
        if (exp_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop_a: got entry pc 0x%0h, want no entry", a_pc);
        end else begin
          ea = exp_a.pop_front();
          chk("pop_a", {18'd0, a_pc, a_op, a_res}, {18'd0, ea});
        end
      end
      if (b_valid) begin
        if (exp_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop_b: got entry pc 0x%0h, want no entry", b_pc);
        end else begin
          eb = exp_b.pop_front();
          chk("pop_b", {18'd0, b_pc, b_op, b_res}, {18'd0, eb});
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step(input logic v, input logic [5:0] op, input logic [7:0] pc, input logic rdy);
    @(posedge clk); #1;
    clr_i = 1'b0; valid_i = v; opcode_i = op; pc_i = pc; result_i = res_of(pc); rd_ready = rdy;
  endtask

  task automatic settle();
    step(1'b0, 6'd0, 8'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    clr_i = 1'b1; valid_i = 1'b0; rd_ready = 1'b0;
    step(1'b0, 6'd0, 8'd0, 1'b0);
    step(1'b0, 6'd0, 8'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 6'd0, 8'd0, 1'b1);
      @(negedge clk);
      if (!a_valid && !b_valid) break;
    end
    chk("drain_a_empty", a_valid, 0);
    chk("drain_b_empty", b_valid, 0);
    step(1'b0, 6'd0, 8'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, want end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_i = 1'b0; en_i = 1'b0; valid_i = 1'b0; rd_ready = 1'b0;
    pc_i = '0; opcode_i = '0; result_i = '0;
    filt_mask_i = 6'h00; filt_val_i = 6'h00; trig_op_i = OP_BEQ;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_level_a", a_level, 0);
    chk("rst_valid_a", a_valid, 0);
    chk("rst_pc_a", a_pc, 0);
    chk("rst_res_b", b_res, 0);
    chk("rst_cnt_r_a", a_r, 0);
    chk("rst_ovf_b", b_ovf, 0);
    chk("rst_frozen_a", a_frz, 0);

`ifdef TRACE_TRIG_EN
    // trigger on BEQ, two captures then freeze
    en_i = 1'b1;
    step(1'b0, 6'd0, 8'd0, 1'b0);
    exp_a.push_back(ent(8'd8, OP_BEQ));  exp_a.push_back(ent(8'd12, OP_ADDI));
    exp_b.push_back(ent(8'd8, OP_BEQ));  exp_b.push_back(ent(8'd12, OP_ADDI));
    step(1'b1, OP_ADD, 8'd0, 1'b0);
    step(1'b1, OP_SUB, 8'd4, 1'b0);
    step(1'b1, OP_BEQ, 8'd8, 1'b0);
    step(1'b1, OP_ADDI, 8'd12, 1'b0);
    step(1'b1, OP_J, 8'd16, 1'b0);
    step(1'b1, OP_ADD, 8'd20, 1'b0);
    settle();
    chk("trig_frozen_a", a_frz, 1);
    chk("trig_frozen_b", b_frz, 1);
    chk("trig_level_a", a_level, 2);
    chk("trig_head_a", a_pc, 8'd8);
    chk("trig_cnt_r", a_r, 2);
    chk("trig_cnt_i", a_i, 2);
    chk("trig_cnt_j", a_j, 0);
    drain();
    do_clr();
    chk("trig_clr_frozen", a_frz, 0);
    chk("trig_clr_level", a_level, 0);
    chk("trig_clr_cnt_r", a_r, 0);
`else
    // three pushes, in-order drain, one per class
    en_i = 1'b1;
    step(1'b0, 6'd0, 8'd0, 1'b0);
    exp_a.push_back(ent(8'd0, OP_ADD)); exp_a.push_back(ent(8'd4, OP_ADDI)); exp_a.push_back(ent(8'd8, OP_J));
    exp_b.push_back(ent(8'd0, OP_ADD)); exp_b.push_back(ent(8'd4, OP_ADDI)); exp_b.push_back(ent(8'd8, OP_J));
    step(1'b1, OP_ADD, 8'd0, 1'b0);
    step(1'b1, OP_ADDI, 8'd4, 1'b0);
    step(1'b1, OP_J, 8'd8, 1'b0);
    settle();
    chk("t1_level_a", a_level, 3);
    chk("t1_level_b", b_level, 3);
    chk("t1_head_a", a_pc, 0);
    chk("t1_cnt_r", a_r, 1);
    chk("t1_cnt_i", a_i, 1);
    chk("t1_cnt_j", a_j, 1);
    drain();
    chk("t1_level_after", a_level, 0);

    // six pushes into DEPTH=4, then a full push+pop
    do_clr();
    chk("clr_cnt_r", a_r, 0);
    chk("clr_level_b", b_level, 0);
    exp_a.push_back(ent(8'd0, OP_ADD));   exp_a.push_back(ent(8'd4, OP_SUB));
    exp_a.push_back(ent(8'd8, OP_ADDI));  exp_a.push_back(ent(8'd12, OP_ANDI));
    exp_a.push_back(ent(8'd24, OP_OR));
    exp_b.push_back(ent(8'd8, OP_ADDI));  exp_b.push_back(ent(8'd12, OP_ANDI));
    exp_b.push_back(ent(8'd16, OP_J));    exp_b.push_back(ent(8'd20, OP_AND));
    exp_b.push_back(ent(8'd24, OP_OR));
    step(1'b1, OP_ADD, 8'd0, 1'b0);
    step(1'b1, OP_SUB, 8'd4, 1'b0);
    step(1'b1, OP_ADDI, 8'd8, 1'b0);
    step(1'b1, OP_ANDI, 8'd12, 1'b0);
    step(1'b1, OP_J, 8'd16, 1'b0);
    step(1'b1, OP_AND, 8'd20, 1'b0);
    settle();
    chk("t2_level_a", a_level, 4);
    chk("t2_head_a", a_pc, 0);
    chk("t2_drop_a", a_drop, 2);
    chk("t2_ovf_a", a_ovf, 1);
    chk("t2_level_b", b_level, 4);
    chk("t2_head_b", b_pc, 8'd8);
    chk("t2_drop_b", b_drop, 2);
    chk("t2_ovf_b", b_ovf, 1);
    chk("t2_frozen_b", b_frz, 0);
    step(1'b1, OP_OR, 8'd24, 1'b1);
    settle();
    chk("t3_level_a", a_level, 4);
    chk("t3_level_b", b_level, 4);
    chk("t3_head_a", a_pc, 8'd4);
    chk("t3_head_b", b_pc, 8'd12);
    chk("t3_drop_a", a_drop, 2);
    chk("t3_drop_b", b_drop, 2);
    chk("t3_cnt_r", a_r, 4);
    chk("t3_cnt_i", b_i, 2);
    chk("t3_cnt_j", b_j, 1);
    drain();

    // opcode filter on LW
    do_clr();
    filt_mask_i = 6'h3F; filt_val_i = OP_LW;
    exp_a.push_back(ent(8'd4, OP_LW)); exp_a.push_back(ent(8'd12, OP_LW));
    exp_b.push_back(ent(8'd4, OP_LW)); exp_b.push_back(ent(8'd12, OP_LW));
    step(1'b1, OP_ADD, 8'd0, 1'b0);
    step(1'b1, OP_LW, 8'd4, 1'b0);
    step(1'b1, OP_SW, 8'd8, 1'b0);
    step(1'b1, OP_LW, 8'd12, 1'b0);
    step(1'b1, OP_J, 8'd16, 1'b0);
    step(1'b1, 6'd30, 8'd20, 1'b0);
    settle();
    chk("t4_level_a", a_level, 2);
    chk("t4_cnt_r", a_r, 1);
    chk("t4_cnt_i", a_i, 3);
    chk("t4_cnt_j", a_j, 1);
    chk("t4_ovf_a", a_ovf, 0);
    drain();
    filt_mask_i = 6'h00; filt_val_i = 6'h00;

    // pop on empty is ignored; disabled capture leaves FIFO and counters alone
    step(1'b0, 6'd0, 8'd0, 1'b1);
    settle();
    chk("t5_empty_level", a_level, 0);
    chk("t5_empty_valid", b_valid, 0);
    en_i = 1'b0;
    step(1'b0, 6'd0, 8'd0, 1'b0);
    step(1'b1, OP_ADD, 8'd40, 1'b0);
    settle();
    chk("t5_idle_level", a_level, 0);
    chk("t5_idle_cnt_r", a_r, 1);
    en_i = 1'b1;
    step(1'b0, 6'd0, 8'd0, 1'b0);

    // asynchronous reset in the middle of operation
    step(1'b1, OP_ADD, 8'd44, 1'b0);
    step(1'b1, OP_ADDI, 8'd48, 1'b0);
    settle();
    chk("t6_level_pre", a_level, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_level", a_level, 0);
    chk("t6_rst_valid", b_valid, 0);
    chk("t6_rst_pc", a_pc, 0);
    chk("t6_rst_cnt_i", a_i, 0);
    @(posedge clk); #1 rst = 1'b0;
`endif

    chk("queue_a_empty", exp_a.size(), 0);
    chk("queue_b_empty", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
